// File: rtl/date_counter_if.sv
// Signal bundle between the date counter and its neighbours: hour-counter carry,
// buttons and edit selectors in, calendar fields and year carry out.
interface date_counter_if;
  logic       ClkDay;
  logic       KeyPlus;
  logic       KeyMinus;
  logic       EditMode;
  logic [2:0] EditPos;
  logic [1:0] screen;
  logic [4:0] days;
  logic [3:0] months;
  logic [6:0] years;
  logic       leap;
  logic       ClkYear;

  modport master (
    output ClkDay, KeyPlus, KeyMinus, EditMode, EditPos, screen,
    input  days, months, years, leap, ClkYear
  );

  modport slave (
    input  ClkDay, KeyPlus, KeyMinus, EditMode, EditPos, screen,
    output days, months, years, leap, ClkYear
  );
endinterface

// File: rtl/date_counter.sv
// Calendar stage: counts day/month/year (2000 + years) on the midnight edge of
// ClkDay, and lets the user step each field with the buttons while in edit mode.
module date_counter #(
  parameter int YEAR_MAX = 99
) (
  input logic         clk,
  input logic         reset,
  date_counter_if.slave bus
);

  localparam logic [6:0] YMAX = 7'(YEAR_MAX);

  logic [4:0] days_q,   days_d;
  logic [3:0] months_q, months_d;
  logic [6:0] years_q,  years_d;
  logic       clk_year_q, clk_year_d;
  logic       cd_q, kp_q, km_q;
  logic       tick, plus, minus, illegal;
  logic [4:0] cur_max;

  function automatic logic [4:0] maxd(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: maxd = 5'd30;
      4'd2:                    maxd = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 maxd = 5'd31;
    endcase
  endfunction

  // Falling edges: ClkDay 1->0 is midnight, keys are active-low.
  assign tick  = cd_q & ~bus.ClkDay;
  assign plus  = kp_q & ~bus.KeyPlus;
  assign minus = km_q & ~bus.KeyMinus;

  assign cur_max = maxd(months_q, years_q);
  assign illegal = (days_q == 5'd0) || (days_q > cur_max) ||
                   (months_q == 4'd0) || (months_q > 4'd12) || (years_q > YMAX);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    days_d     = days_q;
    months_d   = months_q;
    years_d    = years_q;
    clk_year_d = 1'b0;

    if (illegal) begin
      days_d   = 5'd1;
      months_d = 4'd1;
      years_d  = 7'd0;
    end else if (!bus.EditMode) begin
      if (tick) begin
        if (days_q < cur_max) begin
          days_d = days_q + 5'd1;
        end else begin
          days_d = 5'd1;
          if (months_q == 4'd12) begin
            months_d   = 4'd1;
            years_d    = (years_q == YMAX) ? 7'd0 : years_q + 7'd1;
            clk_year_d = 1'b1;
          end else begin
            months_d = months_q + 4'd1;
          end
        end
      end
    end else if (bus.screen == 2'd1 && (plus ^ minus)) begin
      case (bus.EditPos)
        3'd0: begin
          if (plus) days_d = (days_q >= cur_max) ? 5'd1 : days_q + 5'd1;
          else      days_d = (days_q == 5'd1) ? cur_max : days_q - 5'd1;
        end
        3'd1: begin
          if (plus) months_d = (months_q == 4'd12) ? 4'd1 : months_q + 4'd1;
          else      months_d = (months_q == 4'd1) ? 4'd12 : months_q - 4'd1;
        end
        3'd2: begin
          if (plus) years_d = (years_q == YMAX) ? 7'd0 : years_q + 7'd1;
          else      years_d = (years_q == 7'd0) ? YMAX : years_q - 7'd1;
        end
        default: ;
      endcase
      // A shorter month (or a non-leap February) pulls the day down in the same update.
      if (days_d > maxd(months_d, years_d)) days_d = maxd(months_d, years_d);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset) begin
      days_q     <= 5'd1;
      months_q   <= 4'd1;
      years_q    <= 7'd0;
      clk_year_q <= 1'b0;
      cd_q       <= 1'b0;
      kp_q       <= 1'b1;
      km_q       <= 1'b1;
    end else begin
      days_q     <= days_d;
      months_q   <= months_d;
      years_q    <= years_d;
      clk_year_q <= clk_year_d;
      cd_q       <= bus.ClkDay;
      kp_q       <= bus.KeyPlus;
      km_q       <= bus.KeyMinus;
    end
  end

  assign bus.days    = days_q;
  assign bus.months  = months_q;
  assign bus.years   = years_q;
  assign bus.ClkYear = clk_year_q;
  assign bus.leap    = (years_q[1:0] == 2'b00);

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: directed calendar scenarios plus a random
// run compared cycle by cycle against a plain-arithmetic calendar model.
module tb_date_counter;
  localparam int YMAX = 99;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  date_counter_if bus();

  date_counter #(.YEAR_MAX(YMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Calendar model: integers for the date, plus the previous input samples.
  int md, mm, my;
  bit mcy;
  bit m_cd, m_kp, m_km;

  function automatic int mdays(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Advance the model with the inputs as they stand, then clock the DUT.
  task automatic step();
    bit t, p, n;
    int delta, len;
    t = m_cd && !bus.ClkDay;
    p = m_kp && !bus.KeyPlus;
    n = m_km && !bus.KeyMinus;
    mcy = 0;
    if (!reset) begin
      md = 1; mm = 1; my = 0;
      m_cd = 0; m_kp = 1; m_km = 1;
    end else begin
      if (!bus.EditMode) begin
        if (t) begin
          if (md < mdays(mm, my)) md++;
          else begin
            md = 1;
            if (mm == 12) begin mm = 1; my = (my + 1) % (YMAX + 1); mcy = 1; end
            else mm++;
          end
        end
      end else if (bus.screen == 1 && p != n && bus.EditPos <= 2) begin
        delta = p ? 1 : -1;
        case (bus.EditPos)
          0: begin len = mdays(mm, my); md = ((md - 1 + delta + len) % len) + 1; end
          1: mm = ((mm - 1 + delta + 12) % 12) + 1;
          default: my = (my + delta + YMAX + 1) % (YMAX + 1);
        endcase
        if (md > mdays(mm, my)) md = mdays(mm, my);
      end
      m_cd = bus.ClkDay; m_kp = bus.KeyPlus; m_km = bus.KeyMinus;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up);
    if (up) bus.KeyPlus = 1'b0; else bus.KeyMinus = 1'b0;
    step();
    bus.KeyPlus = 1'b1; bus.KeyMinus = 1'b1;
    step();
  endtask

  task automatic day_tick();
    bus.ClkDay = 1'b1;
    step();
    bus.ClkDay = 1'b0;
    step();
  endtask

  // Walk each field to its target through the edit keys; ends in run mode.
  task automatic set_date(input int d, input int m, input int y);
    bus.EditMode = 1'b1; bus.screen = 2'd1;
    bus.EditPos = 3'd2;
    for (int i = 0; i < 128 && my != y; i++) press(1'b1);
    bus.EditPos = 3'd1;
    for (int i = 0; i < 16 && mm != m; i++) press(1'b1);
    bus.EditPos = 3'd0;
    for (int i = 0; i < 40 && md != d; i++) press(1'b1);
    bus.EditMode = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ClkDay = 1'($urandom); bus.KeyPlus = 1'($urandom); bus.KeyMinus = 1'($urandom);
      bus.EditMode = 1'($urandom); bus.EditPos = 3'($urandom); bus.screen = 2'($urandom);
      step();
    end
    checks++;
    if ({bus.days, bus.months, bus.years, bus.ClkYear, bus.leap} !== {5'd1, 4'd1, 7'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d/%0d cy=%0b leap=%0b, expected 1/1/0 cy=0 leap=1",
               bus.days, bus.months, bus.years, bus.ClkYear, bus.leap);
    end
    bus.ClkDay = 1'b0; bus.KeyMinus = 1'b1; bus.KeyPlus = 1'b0; bus.EditMode = 1'b0;
    bus.screen = 2'd1; bus.EditPos = 3'd0;
    step();
    reset = 1'b1;
    step(); step();
    bus.KeyPlus = 1'b1;
    step();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd1, 4'd1, 7'd0}) begin
      errors++;
      $display("FAIL reset_key_held: got %0d/%0d/%0d, expected 1/1/0", bus.days, bus.months, bus.years);
    end
  endtask

  task automatic test_month_end();
    set_date(28, 2, 1);
    day_tick();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd1, 4'd3, 7'd1}) begin
      errors++;
      $display("FAIL feb_nonleap: got %0d/%0d/%0d, expected 1/3/1", bus.days, bus.months, bus.years);
    end
    set_date(28, 2, 4);
    day_tick();
    checks++;
    if ({bus.days, bus.months, bus.years, bus.leap} !== {5'd29, 4'd2, 7'd4, 1'b1}) begin
      errors++;
      $display("FAIL feb_leap_29: got %0d/%0d/%0d leap=%0b, expected 29/2/4 leap=1",
               bus.days, bus.months, bus.years, bus.leap);
    end
    day_tick();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd1, 4'd3, 7'd4}) begin
      errors++;
      $display("FAIL feb_leap_roll: got %0d/%0d/%0d, expected 1/3/4", bus.days, bus.months, bus.years);
    end
  endtask

  task automatic test_year_rollover();
    set_date(31, 12, 5);
    bus.ClkDay = 1'b1;
    step();
    bus.ClkDay = 1'b0;
    step();
    checks++;
    if ({bus.days, bus.months, bus.years, bus.ClkYear} !== {5'd1, 4'd1, 7'd6, 1'b1}) begin
      errors++;
      $display("FAIL year_roll: got %0d/%0d/%0d cy=%0b, expected 1/1/6 cy=1",
               bus.days, bus.months, bus.years, bus.ClkYear);
    end
    step();
    checks++;
    if (bus.ClkYear !== 1'b0) begin
      errors++;
      $display("FAIL clkyear_width: got cy=%0b, expected 0", bus.ClkYear);
    end
    set_date(31, 12, YMAX);
    day_tick();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd1, 4'd1, 7'd0}) begin
      errors++;
      $display("FAIL year_wrap: got %0d/%0d/%0d, expected 1/1/0", bus.days, bus.months, bus.years);
    end
  endtask

  task automatic test_day_edit();
    set_date(30, 4, 7);
    bus.EditMode = 1'b1; bus.screen = 2'd1; bus.EditPos = 3'd0;
    press(1'b1);
    checks++;
    if ({bus.days, bus.months} !== {5'd1, 4'd4}) begin
      errors++;
      $display("FAIL day_plus_wrap: got %0d/%0d, expected 1/4", bus.days, bus.months);
    end
    press(1'b0);
    checks++;
    if ({bus.days, bus.months} !== {5'd30, 4'd4}) begin
      errors++;
      $display("FAIL day_minus_wrap: got %0d/%0d, expected 30/4", bus.days, bus.months);
    end
    bus.screen = 2'd0;
    press(1'b1);
    press(1'b0);
    checks++;
    if ({bus.days, bus.months} !== {5'd30, 4'd4}) begin
      errors++;
      $display("FAIL wrong_screen: got %0d/%0d, expected 30/4", bus.days, bus.months);
    end
    bus.EditMode = 1'b0; bus.screen = 2'd1;
  endtask

  task automatic test_clamp();
    set_date(31, 3, 1);
    bus.EditMode = 1'b1; bus.EditPos = 3'd1;
    press(1'b0);
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd28, 4'd2, 7'd1}) begin
      errors++;
      $display("FAIL clamp_month: got %0d/%0d/%0d, expected 28/2/1", bus.days, bus.months, bus.years);
    end
    set_date(29, 2, 4);
    bus.EditMode = 1'b1; bus.EditPos = 3'd2;
    press(1'b1);
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd28, 4'd2, 7'd5}) begin
      errors++;
      $display("FAIL clamp_year: got %0d/%0d/%0d, expected 28/2/5", bus.days, bus.months, bus.years);
    end
    bus.EditMode = 1'b0;
  endtask

  task automatic test_exclusions();
    set_date(10, 6, 3);
    bus.EditMode = 1'b1; bus.EditPos = 3'd0;
    day_tick();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd10, 4'd6, 7'd3}) begin
      errors++;
      $display("FAIL tick_in_edit: got %0d/%0d/%0d, expected 10/6/3", bus.days, bus.months, bus.years);
    end
    bus.KeyPlus = 1'b0; bus.KeyMinus = 1'b0;
    step();
    bus.KeyPlus = 1'b1; bus.KeyMinus = 1'b1;
    step();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd10, 4'd6, 7'd3}) begin
      errors++;
      $display("FAIL both_keys: got %0d/%0d/%0d, expected 10/6/3", bus.days, bus.months, bus.years);
    end
    bus.EditMode = 1'b0;
    bus.ClkDay = 1'b1;
    step();
    bus.ClkDay = 1'b0; bus.KeyPlus = 1'b0;
    step();
    bus.KeyPlus = 1'b1;
    step();
    checks++;
    if ({bus.days, bus.months, bus.years} !== {5'd11, 4'd6, 7'd3}) begin
      errors++;
      $display("FAIL tick_with_key: got %0d/%0d/%0d, expected 11/6/3", bus.days, bus.months, bus.years);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.ClkDay   = 1'($urandom);
      bus.KeyPlus  = ($urandom_range(0, 3) != 0);
      bus.KeyMinus = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) bus.EditMode = ~bus.EditMode;
      if ($urandom_range(0, 10) == 0) bus.EditPos = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 20) == 0) bus.screen = 2'($urandom);
      step();
      checks++;
      if ({bus.days, bus.months, bus.years, bus.ClkYear, bus.leap} !==
          {5'(md), 4'(mm), 7'(my), mcy, 1'(my % 4 == 0)}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: got %0d/%0d/%0d cy=%0b leap=%0b, expected %0d/%0d/%0d cy=%0b",
                   i, bus.days, bus.months, bus.years, bus.ClkYear, bus.leap, md, mm, my, mcy);
      end
    end
  endtask

  initial begin
    md = 1; mm = 1; my = 0; mcy = 0; m_cd = 0; m_kp = 1; m_km = 1;
    reset = 1'b0;
    bus.ClkDay = 1'b0; bus.KeyPlus = 1'b1; bus.KeyMinus = 1'b1;
    bus.EditMode = 1'b0; bus.EditPos = 3'd0; bus.screen = 2'd1;
    #1;
    test_reset();
    test_month_end();
    test_year_rollover();
    test_day_edit();
    test_clamp();
    test_exclusions();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
